pito_irq_queue: RTL and testbench

PITO_IRQ_QUEUE -- requirements
Module: pito_irq_queue

---
 rtl/pito_irq_queue.sv | 107 ++++++++++
 tb/tb_pito_irq_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pito_irq_queue.sv
// Per-hart MVU interrupt queues. A unicast or broadcast event is pushed into
// one or all hart FIFOs, and each hart pops its own queue with an ack strobe.
// Latency: a push is visible one cycle later. Backpressure: none. A push to a
// full queue with no same-cycle pop is dropped and sets that hart's sticky
// overflow flag.
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   irq_evt_i    {hart_id, data, valid}; hart_id MSB=1 broadcasts to all harts
//   irq_ack_i    per-hart pop strobe (ignored while that queue is empty)
//   ovf_clr_i    per-hart overflow clear (a same-cycle drop wins)
//   mvip_o       per-hart pending level, high while the queue is non-empty
//   irq_data_o   per-hart head-of-queue data, forced to 0 while the queue is empty
//   irq_cnt_o    per-hart occupancy, 0..IRQ_Q_DEPTH
//   irq_ovf_o    per-hart sticky overflow flag

package pito_pkg;
  localparam int NUM_HARTS      = 8;
  localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS);
  localparam int IRQ_Q_DEPTH    = 4;

  typedef struct packed {
    logic [HART_CNT_WIDTH:0] hart_id;  // MSB set = broadcast
    logic [31:0]             data;
    logic                    valid;
  } irq_evt_t;
endpackage

module pito_irq_queue #(
  parameter int NUM_HARTS   = pito_pkg::NUM_HARTS,
  parameter int IRQ_Q_DEPTH = pito_pkg::IRQ_Q_DEPTH,
  localparam int CW         = $clog2(IRQ_Q_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  pito_pkg::irq_evt_t              irq_evt_i,
  input  logic [NUM_HARTS-1:0]            irq_ack_i,
  input  logic [NUM_HARTS-1:0]            ovf_clr_i,
  output logic [NUM_HARTS-1:0]            mvip_o,
  output logic [NUM_HARTS-1:0][31:0]      irq_data_o,
  output logic [NUM_HARTS-1:0][CW-1:0]    irq_cnt_o,
  output logic [NUM_HARTS-1:0]            irq_ovf_o
);

  localparam int PW = $clog2(IRQ_Q_DEPTH);
  localparam int HW = pito_pkg::HART_CNT_WIDTH;

  logic          bcast;
  logic [HW-1:0] tgt;

  assign bcast = irq_evt_i.hart_id[HW];
  assign tgt   = irq_evt_i.hart_id[HW-1:0];

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    localparam logic [HW-1:0] HID = HW'(h);

    logic [31:0]   mem [IRQ_Q_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic push_req;
    logic pop;
    logic full;
    logic do_push;
    logic drop;

    assign push_req = irq_evt_i.valid && (bcast || (tgt == HID));
    // An ack on an empty queue is a no-op, even alongside a push.
    assign pop      = irq_ack_i[h] && (cnt != '0);
    assign full     = (cnt == CW'(IRQ_Q_DEPTH));
    // A same-cycle pop frees the slot, so a full queue can still accept.
    assign do_push  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);

        if (do_push && !pop)      cnt <= cnt + CW'(1);
        else if (!do_push && pop) cnt <= cnt - CW'(1);

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)              ovf <= 1'b1;
        else if (ovf_clr_i[h]) ovf <= 1'b0;
      end
    end

    // Storage is not reset; empty queues mask it at the output.
    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= irq_evt_i.data;
    end

    assign mvip_o[h]     = (cnt != '0);
    assign irq_data_o[h] = (cnt != '0) ? mem[rd_ptr] : 32'h0;
    assign irq_cnt_o[h]  = cnt;
    assign irq_ovf_o[h]  = ovf;
  end

endmodule

// File: tb/tb_pito_irq_queue.sv
module tb_pito_irq_queue;
  localparam int NH = 8;
  localparam int CW = 3;

  logic                     clk;
  logic                     rst_n;
  pito_pkg::irq_evt_t       evt;
  logic [NH-1:0]            ack;
  logic [NH-1:0]            clr;
  logic [NH-1:0]            mvip;
  logic [NH-1:0][31:0]      data;
  logic [NH-1:0][CW-1:0]    cnt;
  logic [NH-1:0]            ovf;

  int checks = 0;
  int errors = 0;

  pito_irq_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_evt_i  (evt),
    .irq_ack_i  (ack),
    .ovf_clr_i  (clr),
    .mvip_o     (mvip),
    .irq_data_o (data),
    .irq_cnt_o  (cnt),
    .irq_ovf_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
    evt.valid = 1'b0;
    ack = '0;
    clr = '0;
  endtask

  task automatic set_evt(input logic [3:0] hid, input logic [31:0] d);
    evt.hart_id = hid;
    evt.data    = d;
    evt.valid   = 1'b1;
  endtask

  task automatic push(input logic [3:0] hid, input logic [31:0] d);
    set_evt(hid, d);
    tick();
  endtask

  task automatic pop(input int h);
    ack[h] = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    evt   = '0;
    ack   = '0;
    clr   = '0;
    #12;
    chk("rst_mvip", 64'(mvip), 64'h0);
    chk("rst_cnt",  64'(cnt),  64'h0);
    chk("rst_ovf",  64'(ovf),  64'h0);
    for (int h = 0; h < NH; h++) chk($sformatf("rst_data%0d", h), 64'(data[h]), 64'h0);
    rst_n = 1'b1;
    tick();

    // Unicast to hart 3
    push(4'd3, 32'hDEAD_0001);
    chk("uni_mvip", 64'(mvip), 64'h08);
    chk("uni_data", 64'(data[3]), 64'hDEAD_0001);
    chk("uni_cnt",  64'(cnt[3]), 64'd1);
    pop(3);
    chk("uni_ack_mvip", 64'(mvip), 64'h00);
    chk("uni_ack_data", 64'(data[3]), 64'h0);

    // Fill and overflow hart 0
    for (int i = 1; i <= 5; i++) push(4'd0, 32'(i));
    chk("fill_cnt", 64'(cnt[0]), 64'd4);
    chk("fill_ovf", 64'(ovf), 64'h01);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fill_pop%0d", i), 64'(data[0]), 64'(i));
      pop(0);
    end
    chk("fill_empty", 64'(mvip[0]), 64'd0);
    chk("fill_ovf_sticky", 64'(ovf), 64'h01);
    clr[0] = 1'b1;
    tick();
    chk("fill_ovf_clr", 64'(ovf), 64'h00);

    // Full hart 2: simultaneous push and pop
    for (int i = 10; i <= 13; i++) push(4'd2, 32'(i));
    set_evt(4'd2, 32'd14);
    ack[2] = 1'b1;
    tick();
    chk("pp_cnt", 64'(cnt[2]), 64'd4);
    chk("pp_ovf", 64'(ovf), 64'h00);
    for (int i = 11; i <= 14; i++) begin
      chk($sformatf("pp_pop%0d", i), 64'(data[2]), 64'(i));
      pop(2);
    end
    chk("pp_empty", 64'(cnt[2]), 64'd0);

    // Broadcast with hart 5 full
    for (int i = 0; i < 4; i++) push(4'd5, 32'h50 + 32'(i));
    push(4'b1000, 32'h55);
    for (int h = 0; h < NH; h++) begin
      if (h == 5) begin
        chk("bc_cnt5", 64'(cnt[h]), 64'd4);
        chk("bc_data5", 64'(data[h]), 64'h50);
      end else begin
        chk($sformatf("bc_cnt%0d", h), 64'(cnt[h]), 64'd1);
        chk($sformatf("bc_data%0d", h), 64'(data[h]), 64'h55);
      end
    end
    chk("bc_ovf", 64'(ovf), 64'h20);
    // Drop and clear on hart 5 in the same cycle: the flag stays set
    clr[5] = 1'b1;
    set_evt(4'b1000, 32'h66);
    tick();
    chk("bc_setwins", 64'(ovf), 64'h20);
    chk("bc_cnt0_2", 64'(cnt[0]), 64'd2);
    clr[5] = 1'b1;
    tick();
    chk("bc_clr5", 64'(ovf), 64'h00);
    ack = '1; tick();
    chk("bc_second0", 64'(data[0]), 64'h66);
    for (int i = 0; i < 3; i++) begin ack = '1; tick(); end
    chk("bc_drained", 64'(mvip), 64'h00);

    // Empty ack on hart 1, then ten push/pop pairs
    pop(1);
    chk("ea_cnt", 64'(cnt[1]), 64'd0);
    chk("ea_mvip", 64'(mvip), 64'h00);
    chk("ea_ovf", 64'(ovf), 64'h00);
    for (int i = 0; i < 10; i++) begin
      push(4'd1, 32'(i));
      chk($sformatf("wrap_data%0d", i), 64'(data[1]), 64'(i));
      pop(1);
      chk($sformatf("wrap_cnt%0d", i), 64'(cnt[1]), 64'd0);
    end

    // Push with ack on an empty queue: push happens, pop is ignored
    set_evt(4'd4, 32'hBEEF);
    ack[4] = 1'b1;
    tick();
    chk("e_pp_cnt", 64'(cnt[4]), 64'd1);
    chk("e_pp_data", 64'(data[4]), 64'hBEEF);
    pop(4);
    chk("e_pp_drain", 64'(mvip), 64'h00);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) push(4'd7, 32'h70 + 32'(i));
    for (int i = 0; i < 5; i++) push(4'd6, 32'h60 + 32'(i));
    chk("mr_cnt7", 64'(cnt[7]), 64'd3);
    chk("mr_ovf", 64'(ovf), 64'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_mvip", 64'(mvip), 64'h0);
    chk("mr_cnt",  64'(cnt),  64'h0);
    chk("mr_ovf0", 64'(ovf),  64'h0);
    chk("mr_data7", 64'(data[7]), 64'h0);
    set_evt(4'b1000, 32'h99);
    ack = '1;
    tick();
    set_evt(4'd7, 32'h98);
    tick();
    chk("mr_held_mvip", 64'(mvip), 64'h0);
    chk("mr_held_cnt",  64'(cnt),  64'h0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("mr_post_mvip", 64'(mvip), 64'h0);
    push(4'd7, 32'h0ABC);
    chk("mr_new_cnt", 64'(cnt[7]), 64'd1);
    chk("mr_new_data", 64'(data[7]), 64'h0ABC);
    chk("mr_new_mvip", 64'(mvip), 64'h80);
    pop(7);
    chk("mr_final", 64'(mvip), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
